// File: rtl/amba3_apb_slave_regs_pkg.sv
// Shared definitions for the AMBA3 APB register slave: FSM state encoding
// and wait-state limits.
package pkg_amba3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

  localparam int MAX_WAIT_CYCLES = 15;
  localparam int WAIT_CNT_BITS   = $clog2(MAX_WAIT_CYCLES + 1);

endpackage

// File: rtl/amba3_apb_slave_regs_if.sv
// APB3 bus bundle shared between a master (bench or bridge) and the register slave.
interface amba3_apb_slave_regs_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);

  logic [ADDR_BITS-1:0] paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [DATA_BITS-1:0] pwdata;
  logic                 pready;
  logic [DATA_BITS-1:0] prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata
  );

endinterface

// File: rtl/amba3_apb_regbank.sv
// Register storage for the APB slave: byte address decode, range check,
// per-register write enable and combinational read of the addressed word.
module amba3_apb_regbank #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int NUM_REGS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 hit
);

  localparam int IDX_BITS = $clog2(NUM_REGS);

  logic [IDX_BITS-1:0]  index;
  logic [DATA_BITS-1:0] regs [NUM_REGS];

  // Word index comes from the bits just above the byte lane; anything set
  // above the index field falls outside the bank.
  assign index   = addr[IDX_BITS+1:2];
  assign hit     = (addr >> (IDX_BITS + 2)) == '0;
  assign rd_data = regs[index];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_BITS-1:0] value_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg <= '0;
        end else if (wr_en && hit && (index == IDX_BITS'(gi))) begin
          value_reg <= wr_data;
        end
      end

      assign regs[gi] = value_reg;
    end
  endgenerate

endmodule

// File: rtl/amba3_apb_slave_regs.sv
// APB3 slave with NUM_REGS read/write registers and a fixed number of wait
// states per transfer; the transfer FSM lives here, storage in the regbank.
module amba3_apb_slave_regs
  import pkg_amba3::*;
#(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic                   pclk,
  input logic                   preset_n,
  amba3_apb_slave_regs_if.slave apb
);

  localparam logic [WAIT_CNT_BITS-1:0] WAIT_INIT = WAIT_CNT_BITS'(WAIT_CYCLES);

  apb_state_e               state_reg;
  logic [WAIT_CNT_BITS-1:0] wait_cnt_reg;
  logic [ADDR_BITS-1:0]     addr_reg;
  logic                     write_reg;
  logic                     pready_reg;
  logic [DATA_BITS-1:0]     prdata_reg;

  logic                 setup_edge;
  logic                 complete;
  logic [ADDR_BITS-1:0] bank_addr;
  logic                 bank_we;
  logic [DATA_BITS-1:0] bank_rdata;
  logic                 bank_hit;
  logic                 rd_is_write;
  logic [DATA_BITS-1:0] rd_value;

  assign setup_edge = apb.psel && !apb.penable;
  assign complete   = apb.psel && apb.penable && pready_reg;

  // In IDLE the setup-phase address is still on the bus (zero-wait reads
  // sample it on the setup edge); afterwards only the latched copy is used.
  assign bank_addr   = (state_reg == IDLE) ? apb.paddr  : addr_reg;
  assign rd_is_write = (state_reg == IDLE) ? apb.pwrite : write_reg;
  assign rd_value    = (rd_is_write || !bank_hit) ? '0 : bank_rdata;
  assign bank_we     = (state_reg == READY) && complete && write_reg;

  amba3_apb_regbank #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .NUM_REGS  (NUM_REGS)
  ) u_regbank (
    .clk     (pclk),
    .rst_n   (preset_n),
    .addr    (bank_addr),
    .wr_en   (bank_we),
    .wr_data (apb.pwdata),
    .rd_data (bank_rdata),
    .hit     (bank_hit)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      pready_reg   <= 1'b0;
      prdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup_edge) begin
            addr_reg     <= apb.paddr;
            write_reg    <= apb.pwrite;
            wait_cnt_reg <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state_reg  <= READY;
              pready_reg <= 1'b1;
              prdata_reg <= rd_value;
            end else begin
              state_reg <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!apb.psel) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - WAIT_CNT_BITS'(1);
            // Counter hits zero on this edge: next cycle is the completing one.
            if (wait_cnt_reg == WAIT_CNT_BITS'(1)) begin
              state_reg  <= READY;
              pready_reg <= 1'b1;
              prdata_reg <= rd_value;
            end
          end
        end

        READY: begin
          if (complete || !apb.psel) begin
            state_reg  <= IDLE;
            pready_reg <= 1'b0;
            prdata_reg <= '0;
          end
        end

        default: begin
          state_reg  <= IDLE;
          pready_reg <= 1'b0;
          prdata_reg <= '0;
        end
      endcase
    end
  end

  assign apb.pready = pready_reg;
  assign apb.prdata = prdata_reg;

endmodule

// File: tb/tb_amba3_apb_slave_regs.sv
// Bench for amba3_apb_slave_regs: three instances (0, 3 and 2 wait states)
// checked cycle by cycle against a word-array model of the register file.
module tb_amba3_apb_slave_regs;

  localparam int NREGS = 16;

  logic        clk;
  logic [2:0]  rst_v;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  pready_v;
  logic [31:0] prdata_v [3];

  int          wt [3] = '{0, 3, 2};
  logic [31:0] mdl [3][NREGS];
  int          vectors = 0;
  int          fails   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      amba3_apb_slave_regs_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

      assign bus.paddr   = paddr;
      assign bus.psel    = psel_v[gi];
      assign bus.penable = penable;
      assign bus.pwrite  = pwrite;
      assign bus.pwdata  = pwdata;
      assign pready_v[gi] = bus.pready;
      assign prdata_v[gi] = bus.prdata;

      amba3_apb_slave_regs #(
        .ADDR_BITS   (32),
        .DATA_BITS   (32),
        .NUM_REGS    (NREGS),
        .WAIT_CYCLES ((gi == 0) ? 0 : ((gi == 1) ? 3 : 2))
      ) dut (
        .pclk     (clk),
        .preset_n (rst_v[gi]),
        .apb      (bus.slave)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] addr);
    return addr < 32'(4 * NREGS);
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [31:0] addr);
    if (!in_range(addr)) return 32'h0;
    return mdl[k][int'(addr / 4)];
  endfunction

  // One APB transfer starting at a falling edge. abort_mode 1 drops psel and
  // abort_mode 2 pulses reset, both at access cycle abort_cycle.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input int abort_mode, input int abort_cycle);
    int          w;
    logic [31:0] exp_rd;
    w      = wt[k];
    exp_rd = model_read(k, addr);
    paddr  = addr;
    pwrite = wr;
    pwdata = data;
    penable = 1'b0;
    psel_v[k] = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    for (int c = 1; c <= w + 1; c++) begin
      check($sformatf("pready d%0d a%h c%0d", k, addr, c), 32'(pready_v[k]), 32'(c == w + 1));
      check($sformatf("prdata d%0d a%h c%0d", k, addr, c), prdata_v[k],
            (c == w + 1 && !wr) ? exp_rd : 32'h0);
      if (abort_mode == 1 && c == abort_cycle) begin
        psel_v[k] = 1'b0;
        penable   = 1'b0;
        @(negedge clk);
        check($sformatf("pready after drop d%0d", k), 32'(pready_v[k]), 32'h0);
        $display("xfer dut%0d %s addr=%h data=%h psel dropped in cycle %0d",
                 k, wr ? "WR" : "RD", addr, data, c);
        return;
      end
      if (abort_mode == 2 && c == abort_cycle) begin
        rst_v[k] = 1'b0;
        #1;
        check($sformatf("pready in reset d%0d", k), 32'(pready_v[k]), 32'h0);
        check($sformatf("prdata in reset d%0d", k), prdata_v[k], 32'h0);
        for (int i = 0; i < NREGS; i++) mdl[k][i] = 32'h0;
        @(negedge clk);
        rst_v[k]  = 1'b1;
        psel_v[k] = 1'b0;
        penable   = 1'b0;
        @(negedge clk);
        $display("xfer dut%0d %s addr=%h data=%h reset in cycle %0d",
                 k, wr ? "WR" : "RD", addr, data, c);
        return;
      end
      @(negedge clk);
    end
    if (wr && in_range(addr)) mdl[k][int'(addr / 4)] = data;
    check($sformatf("pready low after d%0d a%h", k, addr), 32'(pready_v[k]), 32'h0);
    check($sformatf("prdata low after d%0d a%h", k, addr), prdata_v[k], 32'h0);
    psel_v[k] = 1'b0;
    penable   = 1'b0;
    $display("xfer dut%0d %s addr=%h wdata=%h exp_rdata=%h",
             k, wr ? "WR" : "RD", addr, data, wr ? 32'h0 : exp_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NREGS; i++) mdl[k][i] = 32'h0;
    rst_v   = 3'b000;
    psel_v  = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset pready d%0d", k), 32'(pready_v[k]), 32'h0);
      check($sformatf("reset prdata d%0d", k), prdata_v[k], 32'h0);
    end
    rst_v = 3'b111;
    idle(1);

    // Zero-wait write then read
    xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 0, 0);
    idle(1);
    xfer(0, 1'b0, 32'h4, 32'h0, 0, 0);
    idle(1);

    // Three wait states, read of a reset register
    xfer(1, 1'b0, 32'h8, 32'h0, 0, 0);
    idle(1);

    // Out-of-range write is dropped, whole bank unchanged
    xfer(0, 1'b1, 32'h40, 32'h12345678, 0, 0);
    xfer(0, 1'b0, 32'h40, 32'h0, 0, 0);
    for (int i = 0; i < NREGS; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0, 0, 0);
    idle(2);

    // Back-to-back write then read with no idle cycle
    xfer(0, 1'b1, 32'h0, 32'hA5A5A5A5, 0, 0);
    xfer(0, 1'b0, 32'h0, 32'h0, 0, 0);
    idle(1);

    // Reset during the wait phase of a write
    xfer(1, 1'b1, 32'h10, 32'h11112222, 0, 0);
    xfer(1, 1'b1, 32'hC, 32'hFFFFFFFF, 2, 2);
    xfer(1, 1'b0, 32'hC, 32'h0, 0, 0);
    xfer(1, 1'b0, 32'h10, 32'h0, 0, 0);
    idle(1);

    // psel dropped in access cycle 1, then a normal transfer still works
    xfer(2, 1'b1, 32'h8, 32'hCAFEF00D, 1, 1);
    xfer(2, 1'b0, 32'h8, 32'h0, 0, 0);
    xfer(2, 1'b1, 32'h8, 32'h0BADF00D, 0, 0);
    xfer(2, 1'b0, 32'h8, 32'h0, 0, 0);
    idle(1);

    // penable high without a setup phase must be ignored
    paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h55AA55AA;
    psel_v[0] = 1'b1; penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("no-setup pready c%0d", c), 32'(pready_v[0]), 32'h0);
    end
    psel_v[0] = 1'b0; penable = 1'b0;
    $display("xfer dut0 WR addr=00000004 data=55aa55aa without setup phase");
    idle(1);
    xfer(0, 1'b0, 32'h4, 32'h0, 0, 0);

    // Randomized traffic across all three instances
    for (int n = 0; n < 60; n++) begin
      int          k;
      logic        wr;
      logic [31:0] addr;
      int          mode;
      k    = int'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? (32'($urandom_range(64, 255)) | ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0))
                                         : 32'($urandom_range(0, 63));
      mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
      xfer(k, wr, addr, $urandom, mode, int'($urandom_range(1, wt[k] + 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    // Final sweep of every register in every instance
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NREGS; i++) xfer(k, 1'b0, 32'(i * 4 + int'($urandom_range(0, 3))), 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
